// File: rtl/frame_loader_pkg.sv
// Shared types and default sizing for the frame row loader and its row assembler.
package frame_loader_pkg;

  typedef enum logic [1:0] {FILL, ISSUE, RELEASE} state_t;

  localparam int unsigned DEF_ROWS      = 5;
  localparam int unsigned DEF_COLS      = 5;
  localparam int unsigned DEF_MIN_DWELL = 4;
  localparam int unsigned DEF_CNT_W     = 8;

endpackage

// File: rtl/row_assembler.sv
// Builds one ROWSxCOLS frame from row beats; resyncs on sof and flags drops and completion.
module row_assembler
  import frame_loader_pkg::*;
#(
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned WIDTH = ROWS * COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [COLS-1:0]  row_data,
  input  logic             row_sof,
  output logic [WIDTH-1:0] frame_next,
  output logic             done,
  output logic             drop
);

  localparam int unsigned CW = $clog2(ROWS + 1);

  logic [WIDTH-1:0] frame_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // frame_next already contains the row accepted this cycle, so a completing
  // beat can be forwarded to the consumer on the same edge.
  always_comb begin
    frame_next = frame_q;
    cnt_d      = cnt_q;
    done       = 1'b0;
    drop       = 1'b0;
    if (accept) begin
      if (row_sof) begin
        frame_next[WIDTH-1 -: COLS] = row_data;
        drop  = (cnt_q != '0);
        cnt_d = CW'(1);
      end else if (cnt_q != '0) begin
        frame_next[WIDTH - 1 - int'(cnt_q) * COLS -: COLS] = row_data;
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CW'(ROWS)) begin
        done  = 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_next;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_row_loader.sv
// Row-beat to frame loader feeding the perceptron; FSM, dwell guard and frame/drop counters.
// Optional shadow assembler under DOUBLE_BUF_EN.
module frame_row_loader
  import frame_loader_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned WIDTH     = ROWS * COLS,
  parameter int unsigned MIN_DWELL = DEF_MIN_DWELL,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLS-1:0]  row_data,
  input  logic             row_sof,
  input  logic             row_valid,
  output logic             row_ready,
  output logic [WIDTH-1:0] pcp_in,
  output logic             pcp_en,
  input  logic             pcp_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned DW = $clog2(MIN_DWELL + 2);

  state_t           state_q;
  state_t           state_d;
  logic [DW-1:0]    dwell_q;
  logic             accept;
  logic [WIDTH-1:0] asm_frame;
  logic             asm_done;
  logic             asm_drop;
  logic             ready_d;

  assign accept = row_valid & row_ready;

`ifdef DOUBLE_BUF_EN
  logic             sel_q;
  logic             act_b;
  logic             pending_q;
  logic             pending_d;
  logic [WIDTH-1:0] frame_a;
  logic [WIDTH-1:0] frame_b;
  logic             done_a;
  logic             done_b;
  logic             drop_a;
  logic             drop_b;

  // The two assemblers swap roles when a partial shadow frame falls back to
  // FILL, so its rows keep accumulating instead of being lost.
  assign act_b = (state_q == FILL) ? sel_q : ~sel_q;

  row_assembler #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_asm_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept & ~act_b),
    .row_data   (row_data),
    .row_sof    (row_sof),
    .frame_next (frame_a),
    .done       (done_a),
    .drop       (drop_a)
  );

  row_assembler #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_asm_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept & act_b),
    .row_data   (row_data),
    .row_sof    (row_sof),
    .frame_next (frame_b),
    .done       (done_b),
    .drop       (drop_b)
  );

  assign asm_frame = act_b ? frame_b : frame_a;
  assign asm_done  = act_b ? done_b : done_a;
  assign asm_drop  = drop_a | drop_b;

  always_comb begin
    pending_d = pending_q;
    if (state_q == ISSUE && asm_done) pending_d = 1'b1;
    if (state_q == RELEASE)           pending_d = 1'b0;
    ready_d = ~pending_d;
  end
`else
  row_assembler #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .row_data   (row_data),
    .row_sof    (row_sof),
    .frame_next (asm_frame),
    .done       (asm_done),
    .drop       (asm_drop)
  );

  always_comb ready_d = (state_d == FILL);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (asm_done) state_d = ISSUE;
      ISSUE:   if (dwell_q == DW'(MIN_DWELL) && pcp_ready) state_d = RELEASE;
      RELEASE: begin
        state_d = FILL;
`ifdef DOUBLE_BUF_EN
        if (pending_q || asm_done) state_d = ISSUE;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      dwell_q   <= '0;
      pcp_en    <= 1'b0;
      pcp_in    <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      row_ready <= 1'b0;
`ifdef DOUBLE_BUF_EN
      sel_q     <= 1'b0;
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_ready <= ready_d;
      pcp_en    <= (state_d == ISSUE);
      if (asm_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (state_q == ISSUE && state_d == RELEASE) frame_cnt <= frame_cnt + 1'b1;
      if (state_d == ISSUE && state_q != ISSUE) begin
        pcp_in  <= asm_frame;
        dwell_q <= '0;
      end else if (state_q == ISSUE && dwell_q != DW'(MIN_DWELL)) begin
        dwell_q <= dwell_q + 1'b1;
      end
`ifdef DOUBLE_BUF_EN
      pending_q <= pending_d;
      if (state_q == RELEASE && state_d == FILL) sel_q <= ~sel_q;
`endif
    end
  end

endmodule

// File: tb/tb_frame_row_loader.sv
// Self-checking bench for frame_row_loader: directed scenarios plus randomized run against a queue-based model.
module tb_frame_row_loader;

  localparam int unsigned ROWS      = 5;
  localparam int unsigned COLS      = 5;
  localparam int unsigned WIDTH     = 25;
  localparam int unsigned MIN_DWELL = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [COLS-1:0]  row_data = '0;
  logic             row_sof = 1'b0;
  logic             row_valid = 1'b0;
  logic             row_ready;
  logic [WIDTH-1:0] pcp_in;
  logic             pcp_en;
  logic             pcp_ready = 1'b0;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  frame_row_loader #(
    .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .MIN_DWELL(MIN_DWELL), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_data  (row_data),
    .row_sof   (row_sof),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .pcp_in    (pcp_in),
    .pcp_en    (pcp_en),
    .pcp_ready (pcp_ready),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  // Reference model: frame as a queue of rows, phases as plain integers.
  int               m_phase;
  int               m_age;
  logic [COLS-1:0]  m_q[$];
  logic [WIDTH-1:0] m_in;
  logic             m_en;
  logic             m_ready;
  int unsigned      m_fcnt;
  int unsigned      m_dcnt;

  task automatic model_step(input logic r, input logic v, input logic s,
                            input logic [COLS-1:0] d, input logic pr);
    logic acc;
    acc = v & m_ready;
    if (!r) begin
      m_phase = 0; m_age = 0; m_q.delete(); m_in = '0;
      m_en = 1'b0; m_ready = 1'b0; m_fcnt = 0; m_dcnt = 0;
      return;
    end
    case (m_phase)
      0: if (acc) begin
        if (s) begin
          if (m_q.size() != 0 && m_dcnt < CNT_MAX) m_dcnt++;
          m_q.delete();
          m_q.push_back(d);
        end else if (m_q.size() != 0) begin
          m_q.push_back(d);
        end
        if (m_q.size() == ROWS) begin
          m_in = '0;
          foreach (m_q[i]) m_in = (m_in << COLS) | WIDTH'(m_q[i]);
          m_q.delete();
          m_phase = 1; m_age = 0; m_en = 1'b1;
        end
      end
      1: if (m_age >= int'(MIN_DWELL) && pr) begin
        m_phase = 2; m_en = 1'b0; m_fcnt = (m_fcnt + 1) % (CNT_MAX + 1);
      end else begin
        m_age++;
      end
      default: m_phase = 0;
    endcase
    m_ready = (m_phase == 0);
  endtask

  // Drive one cycle of inputs, advance past the edge, sample point is #1 after it.
  task automatic tick(input logic v, input logic s, input logic [COLS-1:0] d,
                      input logic pr, output logic acc);
    row_valid = v; row_sof = s; row_data = d; pcp_ready = pr;
    acc = v & row_ready;
    @(posedge clk); #1;
    model_step(rst_n, v, s, d, pr);
  endtask

  task automatic do_reset(input int unsigned n);
    logic a;
    rst_n = 1'b0;
    repeat (n) tick(1'b0, 1'b0, '0, 1'b0, a);
    rst_n = 1'b1;
  endtask

  logic [COLS-1:0] x_rows[ROWS] = '{5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001};
  logic [COLS-1:0] o_rows[ROWS] = '{5'b00100, 5'b01010, 5'b10001, 5'b01010, 5'b00100};

  task automatic test_reset();
    logic a;
    do_reset(3);
    n_cmp++; if (pcp_en !== 1'b0) begin n_bad++; $display("FAIL reset_pcp_en: got %b want 0", pcp_en); end
    n_cmp++; if (pcp_in !== '0) begin n_bad++; $display("FAIL reset_pcp_in: got %h want 0", pcp_in); end
    n_cmp++; if (frame_cnt !== '0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    n_cmp++; if (row_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", row_ready); end
    tick(1'b0, 1'b0, '0, 1'b0, a);
    n_cmp++; if (row_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_rise: got %b want 1", row_ready); end
  endtask

  task automatic test_frame();
    logic a;
    do_reset(2);
    tick(1'b0, 1'b0, '0, 1'b0, a);
    for (int i = 0; i < int'(ROWS); i++) begin
      tick(1'b1, i == 0, x_rows[i], 1'b0, a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL frame_accept%0d: got %b want 1", i, a); end
      if (i == int'(ROWS) - 2) begin
        n_cmp++; if (pcp_en !== 1'b0) begin n_bad++; $display("FAIL frame_en_early: got %b want 0", pcp_en); end
      end
    end
    row_valid = 1'b0;
    n_cmp++; if (pcp_en !== 1'b1) begin n_bad++; $display("FAIL frame_en: got %b want 1", pcp_en); end
    n_cmp++; if (pcp_in !== 25'h1151151) begin n_bad++; $display("FAIL frame_pcp_in: got %h want 1151151", pcp_in); end
  endtask

  task automatic test_dwell();
    logic a;
    int unsigned hi;
    hi = 1;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 1'b0, '0, 1'b1, a);
      if (pcp_en) hi++;
      else break;
    end
    n_cmp++; if (hi !== MIN_DWELL + 1) begin n_bad++; $display("FAIL dwell_len: got %0d want %0d", hi, MIN_DWELL + 1); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL dwell_frame_cnt: got %0d want 1", frame_cnt); end
    n_cmp++; if (pcp_in !== 25'h1151151) begin n_bad++; $display("FAIL dwell_pcp_in_held: got %h want 1151151", pcp_in); end
    tick(1'b0, 1'b0, '0, 1'b1, a);
    n_cmp++; if (row_ready !== 1'b1) begin n_bad++; $display("FAIL dwell_back_to_fill: got %b want 1", row_ready); end
    n_cmp++; if (pcp_en !== 1'b0) begin n_bad++; $display("FAIL dwell_en_after: got %b want 0", pcp_en); end
  endtask

  task automatic test_resync();
    logic a;
    logic [COLS-1:0] part[3] = '{5'b11111, 5'b00000, 5'b11111};
    do_reset(2);
    tick(1'b0, 1'b0, '0, 1'b0, a);
    for (int i = 0; i < 3; i++) tick(1'b1, i == 0, part[i], 1'b0, a);
    for (int i = 0; i < int'(ROWS); i++) tick(1'b1, i == 0, o_rows[i], 1'b0, a);
    row_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL resync_drop: got %0d want 1", drop_cnt); end
    n_cmp++; if (pcp_en !== 1'b1) begin n_bad++; $display("FAIL resync_en: got %b want 1", pcp_en); end
    n_cmp++; if (pcp_in !== 25'h0454544) begin n_bad++; $display("FAIL resync_pcp_in: got %h want 0454544", pcp_in); end
    repeat (8) tick(1'b0, 1'b0, '0, 1'b1, a);
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL resync_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic was_en;
    logic seen_low;
    logic fin;
    int unsigned idx;
    int unsigned low;
    int unsigned acc_hi;
    int unsigned exp_low;
    int unsigned exp_acc;
`ifdef DOUBLE_BUF_EN
    exp_low = 1; exp_acc = ROWS;
`else
    exp_low = ROWS + 1; exp_acc = 0;
`endif
    do_reset(2);
    tick(1'b0, 1'b0, '0, 1'b0, a);
    for (int i = 0; i < int'(ROWS); i++) tick(1'b1, i == 0, x_rows[i], 1'b0, a);
    idx = 0; low = 0; acc_hi = 0; seen_low = 1'b0; fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      was_en = pcp_en;
      tick(idx < ROWS, idx == 0, o_rows[idx < ROWS ? idx : 0], 1'b1, a);
      if (a) begin
        if (was_en) acc_hi++;
        idx++;
      end
      if (!pcp_en) begin low++; seen_low = 1'b1; end
      else if (seen_low) fin = 1'b1;
    end
    row_valid = 1'b0;
    n_cmp++; if (fin !== 1'b1) begin n_bad++; $display("FAIL b2b_second_issue: got %b want 1", fin); end
    n_cmp++; if (low !== exp_low) begin n_bad++; $display("FAIL b2b_en_low: got %0d want %0d", low, exp_low); end
    n_cmp++; if (acc_hi !== exp_acc) begin n_bad++; $display("FAIL b2b_accept_in_issue: got %0d want %0d", acc_hi, exp_acc); end
    n_cmp++; if (pcp_in !== 25'h0454544) begin n_bad++; $display("FAIL b2b_pcp_in: got %h want 0454544", pcp_in); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_drop_saturate();
    logic a;
    do_reset(2);
    tick(1'b0, 1'b0, '0, 1'b0, a);
    tick(1'b1, 1'b1, 5'b10101, 1'b0, a);
    tick(1'b1, 1'b0, 5'b01010, 1'b0, a);
    for (int i = 1; i <= 300; i++) begin
      tick(1'b1, 1'b1, 5'b11100, 1'b0, a);
      if (i == 1) begin
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL sat_first: got %0d want 1", drop_cnt); end
      end
      if (i == 255) begin
        n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", drop_cnt); end
      end
    end
    row_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL sat_no_frame: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_random();
`ifndef DOUBLE_BUF_EN
    logic a;
    logic v;
    logic s;
    logic pr;
    logic [COLS-1:0] d;
    do_reset(2);
    for (int c = 0; c < 800; c++) begin
      v  = ($urandom_range(0, 99) < 75);
      s  = ($urandom_range(0, 99) < 15);
      pr = ($urandom_range(0, 99) < 40);
      d  = COLS'($urandom);
      tick(v, s, d, pr, a);
      n_cmp++; if (row_ready !== m_ready) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, row_ready, m_ready); end
      n_cmp++; if (pcp_en !== m_en) begin n_bad++; $display("FAIL rnd_en c%0d: got %b want %b", c, pcp_en, m_en); end
      n_cmp++; if (pcp_in !== m_in) begin n_bad++; $display("FAIL rnd_pcp_in c%0d: got %h want %h", c, pcp_in, m_in); end
      n_cmp++; if (frame_cnt !== CNT_W'(m_fcnt)) begin n_bad++; $display("FAIL rnd_frame_cnt c%0d: got %0d want %0d", c, frame_cnt, m_fcnt); end
      n_cmp++; if (drop_cnt !== CNT_W'(m_dcnt)) begin n_bad++; $display("FAIL rnd_drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_dcnt); end
    end
    row_valid = 1'b0;
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_frame();
    test_dwell();
    test_resync();
    test_back_to_back();
    test_drop_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
